spi_shift_engine: RTL and testbench
===================================

// Module: spi_shift_engine
// PURPOSE
//  Byte-level SPI master for the boot flash, sitting directly downstream of the Z180 bus bridge FSM.
//  The bridge issues one request per byte: direction, single/dual mode and TX byte.
//  This block generates SCK, drives or tristates IO0/IO1, and returns the RX byte with a done pulse.
//  It exports the remaining bit count so the bridge can decide when to hold /WAIT.
// PARAMETERS
//  CLKDIV   1   CLK1 cycles per SCK half-period (>=1); SCK = CLK1/(2*CLKDIV)
// PORTS
//  CLK1       in   1  system clock; the only clock
//  RST        in   1  synchronous, active-high reset
//  start      in   1  request strobe; accepted only when busy==0 (done cycle included)
//  dir        in   1  0=READ, 1=WRITE; sampled with start
//  mode       in   1  0=SINGLE, 1=DUAL; sampled with start
//  tx_data    in   8  byte to send, MSB first; sampled with start
//  abort      in   1  cancel the transfer in progress; no done pulse
//  sdo_in     in   1  pad input, IO0/MOSI
//  sdi_in     in   1  pad input, IO1/MISO
//  sck        out  1  SPI clock, idles low (mode 0)
//  sdo_out    out  1  IO0 drive value
//  sdo_oe     out  1  IO0 output enable
//  sdi_out    out  1  IO1 drive value
//  sdi_oe     out  1  IO1 output enable
//  busy       out  1  transfer in progress
//  done       out  1  one-cycle pulse; rx_data valid from this cycle on
//  rx_data    out  8  received byte, held until the next done
//  bits_left  out  4  bits not yet sampled: 8..1 single, 8/6/4/2 dual, 0 when idle
// BEHAVIOUR
//  Reset: state IDLE; sck=0, busy=0, done=0, both oe=0, rx_data=8'h00, bits_left=0, outs=0.
//  States: IDLE -> LOW -> HIGH -> (LOW | IDLE). Each phase lasts CLKDIV cycles, timed by a phase counter.
//  Start accept (IDLE && start): latch dir/mode/tx_data into the shift register.
//    bits_left=8; enter LOW with sck=0. Data out is valid from the first busy cycle.
//  LOW->HIGH edge: sck->1; sample pads into the shift register LSBs.
//    SINGLE: {sdi_in}. DUAL: {sdi_in,sdo_in}.
//    bits_left -= 1 (SINGLE) or 2 (DUAL).
//  HIGH->LOW edge (bits_left!=0): sck->0; shift left by 1 (SINGLE) or 2 (DUAL).
//  HIGH end with bits_left==0: -> IDLE, sck=0, busy=0, done=1 for one cycle, rx_data<=shift reg.
//  Drive rules while busy:
//    SINGLE:       sdo_oe=1, sdo_out=sr[7]; sdi_oe=0.
//    DUAL WRITE:   sdi_oe=1, sdi_out=sr[7]; sdo_oe=1, sdo_out=sr[6].
//    DUAL READ:    both oe=0.
//    SINGLE READ:  sdo_out=sr[7], which shifts in sampled data; the flash ignores it.
//  Idle: both oe=0.
//  Latency: start accepted at cycle 0 -> done in cycle 16*CLKDIV+1 (SINGLE), 8*CLKDIV+1 (DUAL).
//  start while busy: ignored, not queued. start in the done cycle is accepted (back-to-back).
//  abort: next cycle IDLE, sck=0, oe=0, no done, rx_data unchanged.
//    Abort wins over start in the same cycle.
//  RST mid-transfer: identical to reset values; rx_data cleared.
//  CLKDIV=1: sck toggles every CLK1 cycle.
// STRUCTURE
//  Shared header spi_defs.vh: SPI_READ=0, SPI_WRITE=1, SPI_SINGLE=0, SPI_DUAL=1, state encodings.
//  One sub-module, spi_phase_timer: counter reloaded to CLKDIV-1.
//    Emits phase_end when it reaches 0; cleared in IDLE.
//  Shift register, bit counter and FSM stay in this module.
// TESTING
//  1. SINGLE WRITE tx=8'hA5, CLKDIV=1: sdo_out on sck rising = 1,0,1,0,0,1,0,1.
//     done in cycle 17; sdi_oe=0 throughout.
//  2. SINGLE READ: flash model returns 8'h3C on sdi_in -> rx_data=8'h3C at done.
//     bits_left steps 8..1 then 0.
//  3. DUAL WRITE tx=8'hB4: {sdi_out,sdo_out} per rising edge = 10,11,01,00.
//     done in cycle 9; both oe=1 while busy.
//  4. DUAL READ: model drives {IO1,IO0}=01,11,00,10 -> rx_data=8'h72.
//     Both oe=0; bits_left 8,6,4,2,0.
//  5. start held high across done -> second transfer begins with no idle gap.
//     start pulsed mid-transfer is ignored.
//  6. abort at bits_left=4 -> sck=0, busy=0 next cycle, no done, rx_data keeps prior 8'h3C.
//     Repeat with RST -> rx_data=8'h00.
//     Repeat test 1 with CLKDIV=3 -> done in cycle 49.

Source files
------------

// File: rtl/spi_shift_engine_pkg.sv
// ---------------------------------------------------------------------------
// spi_shift_engine_pkg
// Shared definitions for the boot-flash SPI byte engine: transfer direction
// and width encodings, FSM state encoding and the per-edge bit step helper.
// ---------------------------------------------------------------------------
package spi_shift_engine_pkg;

    localparam logic SPI_READ   = 1'b0;
    localparam logic SPI_WRITE  = 1'b1;
    localparam logic SPI_SINGLE = 1'b0;
    localparam logic SPI_DUAL   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

    // Bits moved per SCK period: one line in single mode, two in dual mode.
    function automatic logic [3:0] bit_step(input logic mode);
        return (mode == SPI_DUAL) ? 4'd2 : 4'd1;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// ---------------------------------------------------------------------------
// spi_phase_timer
// Times one SCK half-period. While run_i is high the counter counts down
// from CLKDIV-1; phase_end_o is high in the last cycle of each phase and the
// counter reloads. While run_i is low the counter sits at its reload value so
// the first phase after a start lasts a full CLKDIV cycles.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   run_i        engine is in a LOW or HIGH phase
//   phase_end_o  current cycle is the last of the phase
// ---------------------------------------------------------------------------
module spi_phase_timer #(
    parameter int CLKDIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic phase_end_o
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_end_o = run_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_shift_engine
// Byte-level SPI master (mode 0) for the boot flash. One request per byte:
// direction, single/dual width and TX byte are latched on start. Generates
// SCK, drives or releases IO0/IO1, returns the received byte with a done
// pulse and reports bits still to be sampled.
// Ports:
//   CLK1, RST             clock, synchronous active-high reset
//   start/dir/mode/tx_data request strobe and its qualifiers
//   abort                 cancel the transfer in progress (no done)
//   sdo_in, sdi_in        IO0 / IO1 pad inputs
//   sck                   SPI clock, idles low
//   sdo_out/sdo_oe        IO0 drive value and enable
//   sdi_out/sdi_oe        IO1 drive value and enable
//   busy, done, rx_data   status, completion pulse, received byte
//   bits_left             bits not yet sampled (0 when idle)
// ---------------------------------------------------------------------------
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int CLKDIV = 1
) (
    input  logic       CLK1,
    input  logic       RST,
    input  logic       start,
    input  logic       dir,
    input  logic       mode,
    input  logic [7:0] tx_data,
    input  logic       abort,
    input  logic       sdo_in,
    input  logic       sdi_in,
    output logic       sck,
    output logic       sdo_out,
    output logic       sdo_oe,
    output logic       sdi_out,
    output logic       sdi_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic [3:0] bits_left
);

    spi_state_e  state_q, state_d;
    logic        dir_q, dir_d;
    logic        mode_q, mode_d;
    // The TX byte sits in [9:2]; the two spare LSBs take sampled pad bits so
    // that sampling on the rising edge never overwrites a TX bit still to go
    // out. After the final sample the received byte is exactly sr_q[7:0].
    logic [9:0]  sr_q, sr_d;
    logic [3:0]  bits_q, bits_d;
    logic        done_q, done_d;
    logic [7:0]  rx_q, rx_d;
    logic        phase_end;

    spi_phase_timer #(
        .CLKDIV (CLKDIV)
    ) u_timer (
        .clk_i       (CLK1),
        .rst_i       (RST),
        .run_i       (state_q != ST_IDLE),
        .phase_end_o (phase_end)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        sr_d    = sr_q;
        bits_d  = bits_q;
        done_d  = 1'b0;
        rx_d    = rx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    mode_d  = mode;
                    sr_d    = {tx_data, 2'b00};
                    bits_d  = 4'd8;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    // Rising SCK edge: capture pads into the spare LSBs.
                    if (mode_q == SPI_DUAL) begin
                        sr_d = {sr_q[9:2], sdi_in, sdo_in};
                    end else begin
                        sr_d = {sr_q[9:1], sdi_in};
                    end
                    bits_d  = bits_q - bit_step(mode_q);
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    if (bits_q == 4'd0) begin
                        rx_d    = sr_q[7:0];
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Falling SCK edge: present the next TX bit(s).
                        if (mode_q == SPI_DUAL) begin
                            sr_d = {sr_q[7:0], 2'b00};
                        end else begin
                            sr_d = {sr_q[8:0], 1'b0};
                        end
                        state_d = ST_LOW;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start seen in IDLE.
        if (abort) begin
            state_d = ST_IDLE;
            bits_d  = 4'd0;
            done_d  = 1'b0;
            rx_d    = rx_q;
        end
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            state_q <= ST_IDLE;
            dir_q   <= SPI_READ;
            mode_q  <= SPI_SINGLE;
            sr_q    <= '0;
            bits_q  <= 4'd0;
            done_q  <= 1'b0;
            rx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign sck       = (state_q == ST_HIGH);
    assign done      = done_q;
    assign rx_data   = rx_q;
    assign bits_left = bits_q;

    always_comb begin
        sdo_out = 1'b0;
        sdo_oe  = 1'b0;
        sdi_out = 1'b0;
        sdi_oe  = 1'b0;
        if (busy) begin
            if (mode_q == SPI_SINGLE) begin
                // In single read the flash ignores IO0, so it is driven anyway.
                sdo_oe  = 1'b1;
                sdo_out = sr_q[9];
            end else if (dir_q == SPI_WRITE) begin
                sdi_oe  = 1'b1;
                sdi_out = sr_q[9];
                sdo_oe  = 1'b1;
                sdo_out = sr_q[8];
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;

    logic       CLK1 = 1'b0;
    logic       RST, start, dir, mode, abort, sdo_in, sdi_in;
    logic [7:0] tx_data;

    logic       sck, sdo_out, sdo_oe, sdi_out, sdi_oe, busy, done;
    logic [7:0] rx_data;
    logic [3:0] bits_left;

    logic       c3_sck, c3_sdo_out, c3_sdo_oe, c3_sdi_out, c3_sdi_oe, c3_busy, c3_done;
    logic [7:0] c3_rx_data;
    logic [3:0] c3_bits_left;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK1 = ~CLK1;

    spi_shift_engine #(.CLKDIV(1)) dut (
        .CLK1(CLK1), .RST(RST), .start(start), .dir(dir), .mode(mode),
        .tx_data(tx_data), .abort(abort), .sdo_in(sdo_in), .sdi_in(sdi_in),
        .sck(sck), .sdo_out(sdo_out), .sdo_oe(sdo_oe), .sdi_out(sdi_out),
        .sdi_oe(sdi_oe), .busy(busy), .done(done), .rx_data(rx_data),
        .bits_left(bits_left)
    );

    spi_shift_engine #(.CLKDIV(3)) dut3 (
        .CLK1(CLK1), .RST(RST), .start(start), .dir(dir), .mode(mode),
        .tx_data(tx_data), .abort(abort), .sdo_in(sdo_in), .sdi_in(sdi_in),
        .sck(c3_sck), .sdo_out(c3_sdo_out), .sdo_oe(c3_sdo_oe), .sdi_out(c3_sdi_out),
        .sdi_oe(c3_sdi_oe), .busy(c3_busy), .done(c3_done), .rx_data(c3_rx_data),
        .bits_left(c3_bits_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    // Pulse start for one cycle; returns in cycle 1 of the transfer.
    task automatic start_xfer(input logic d, input logic m, input logic [7:0] tx);
        start = 1'b1; dir = d; mode = m; tx_data = tx;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] byte_v;
        logic [1:0] p3 [4];
        logic [1:0] p4 [4];

        RST = 1'b1; start = 1'b0; dir = 1'b0; mode = 1'b0; abort = 1'b0;
        sdo_in = 1'b0; sdi_in = 1'b0; tx_data = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_sck", sck, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sdo_oe", sdo_oe, 0);
        chk("rst_sdi_oe", sdi_oe, 0);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_bits", bits_left, 0);
        chk("rst_outs", {sdi_out, sdo_out}, 0);
        RST = 1'b0;
        tick();

        // 1: single write A5, CLKDIV=1
        byte_v = 8'hA5;
        start_xfer(1'b1, 1'b0, byte_v);
        for (int c = 1; c <= 16; c++) begin
            chk("t1_busy", busy, 1);
            chk("t1_done_lo", done, 0);
            chk("t1_sdi_oe", sdi_oe, 0);
            chk("t1_sdo_oe", sdo_oe, 1);
            chk("t1_sck", sck, (c % 2 == 0) ? 1 : 0);
            if (c % 2 == 0) chk("t1_sdo_bit", sdo_out, byte_v[7 - (c/2 - 1)]);
            tick();
        end
        chk("t1_done17", done, 1);
        chk("t1_busy17", busy, 0);
        chk("t1_sck17", sck, 0);
        chk("t1_oe17", {sdi_oe, sdo_oe}, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // 3: dual write B4
        p3 = '{2'b10, 2'b11, 2'b01, 2'b00};
        start_xfer(1'b1, 1'b1, 8'hB4);
        for (int c = 1; c <= 8; c++) begin
            chk("t3_oe", {sdi_oe, sdo_oe}, 2'b11);
            chk("t3_done_lo", done, 0);
            if (c % 2 == 0) begin
                chk("t3_sck", sck, 1);
                chk("t3_pair", {sdi_out, sdo_out}, p3[c/2 - 1]);
            end
            tick();
        end
        chk("t3_done9", done, 1);
        chk("t3_busy9", busy, 0);
        chk("t3_oe9", {sdi_oe, sdo_oe}, 0);

        // 4: dual read, flash drives 01,11,00,10 -> 72
        p4 = '{2'b01, 2'b11, 2'b00, 2'b10};
        start_xfer(1'b0, 1'b1, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            if (c % 2 == 1) {sdi_in, sdo_in} = p4[(c-1)/2];
            chk("t4_oe", {sdi_oe, sdo_oe}, 0);
            chk("t4_bits", bits_left, 8 - 2*(c/2));
            tick();
        end
        {sdi_in, sdo_in} = 2'b00;
        chk("t4_done9", done, 1);
        chk("t4_rx", rx_data, 8'h72);
        chk("t4_bits9", bits_left, 0);

        // 5: start held across done, then a mid-transfer pulse
        start = 1'b1; dir = 1'b1; mode = 1'b0; tx_data = 8'h5A;
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c == 10) tx_data = 8'hC3;
            tick();
        end
        chk("t5_done17", done, 1);
        chk("t5_busy17", busy, 0);
        tick();
        start = 1'b0;
        chk("t5_busy18", busy, 1);
        chk("t5_bits18", bits_left, 8);
        chk("t5_msb18", sdo_out, 1);
        for (int c = 18; c < 34; c++) begin
            if (c == 22) begin
                start = 1'b1; tx_data = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (c == 24) chk("t5_bits_ignored", bits_left, 5);
            if (c == 33) begin
                chk("t5_sck33", sck, 1);
                chk("t5_lsb33", sdo_out, 1);
            end
            tick();
        end
        start = 1'b0;
        chk("t5_done34", done, 1);
        chk("t5_rx34", rx_data, 8'h00);

        // 2: single read 3C
        byte_v = 8'h3C;
        start_xfer(1'b0, 1'b0, 8'hFF);
        for (int c = 1; c <= 16; c++) begin
            if (c % 2 == 1) sdi_in = byte_v[7 - (c-1)/2];
            chk("t2_bits", bits_left, 8 - c/2);
            chk("t2_sdi_oe", sdi_oe, 0);
            tick();
        end
        sdi_in = 1'b0;
        chk("t2_done17", done, 1);
        chk("t2_rx", rx_data, 8'h3C);
        chk("t2_bits17", bits_left, 0);

        // 6: abort at bits_left=4
        sdi_in = 1'b1;
        start_xfer(1'b0, 1'b0, 8'hFF);
        for (int c = 1; c < 8; c++) tick();
        chk("t6_bits8", bits_left, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_sck", sck, 0);
        chk("t6_oe", {sdi_oe, sdo_oe}, 0);
        chk("t6_bits", bits_left, 0);
        chk("t6_rx_kept", rx_data, 8'h3C);
        for (int c = 0; c < 12; c++) begin
            chk("t6_no_done", done, 0);
            tick();
        end
        sdi_in = 1'b0;

        // abort wins over start in the same idle cycle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t6_abort_vs_start", busy, 0);

        // RST mid-transfer
        start_xfer(1'b0, 1'b0, 8'hFF);
        for (int c = 1; c < 8; c++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t6r_busy", busy, 0);
        chk("t6r_rx", rx_data, 8'h00);
        chk("t6r_bits", bits_left, 0);
        chk("t6r_sck", sck, 0);
        chk("t6r_c3_busy", c3_busy, 0);

        // Test 1 again on the CLKDIV=3 instance
        byte_v = 8'hA5;
        start_xfer(1'b1, 1'b0, byte_v);
        for (int c = 1; c <= 48; c++) begin
            chk("t7_busy", c3_busy, 1);
            chk("t7_done_lo", c3_done, 0);
            chk("t7_sck", c3_sck, ((c-1) % 6 >= 3) ? 1 : 0);
            if ((c-1) % 6 == 3) chk("t7_sdo_bit", c3_sdo_out, byte_v[7 - (c-1)/6]);
            tick();
        end
        chk("t7_done49", c3_done, 1);
        chk("t7_busy49", c3_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
